// File: rtl/pwl_cmd_builder.sv
// rtl/pwl_cmd_builder.sv - turns PWL breakpoint pairs into batch-aligned region commands
// Slope comes from a sequential restoring divider; each region is split into head/body/tail pieces.
module pwl_cmd_builder #(
  parameter int SAMPLE_WIDTH   = 16,
  parameter int BATCH_SIZE     = 16,
  parameter int DMA_DATA_WIDTH = 4*SAMPLE_WIDTH
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [2*SAMPLE_WIDTH-1:0]   in_data,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic                        in_last,
  output logic [DMA_DATA_WIDTH-1:0]   out_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        out_last,
  output logic                        error
);
  localparam int W  = SAMPLE_WIDTH;
  localparam int CW = $clog2(2*W);
  localparam logic [W-1:0] BMASK = W'(BATCH_SIZE-1);
  localparam logic [W-1:0] MAXDT = W'((1 << (W-1)) - 1);

  typedef enum logic [2:0] {IDLE, LOAD, DIVIDE, EMIT_HEAD, EMIT_BODY, EMIT_TAIL, ERROR} state_t;

  state_t          state_q, state_d;
  logic            ready_en_q, ready_en_d;
  logic            error_q, error_d;
  logic            last_q, last_d;
  logic            neg_q, neg_d;
  logic [W-1:0]    t0_q, t0_d, x0_q, x0_d, t1_q, t1_d, x1_q, x1_d;
  logic [2*W-1:0]  num_q, num_d;
  logic [W-2:0]    rem_q, rem_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic [W-1:0]    in_t, in_x;
  logic            in_acc, out_acc;
  logic [W-1:0]    dt, h, head, rest, body, tail;
  logic [W:0]      diff;
  logic [W-1:0]    mag;
  logic [W-1:0]    rem_sh;
  logic            q_bit, bad_t1;
  logic [2*W-1:0]  slope, k_ext;
  logic [W-1:0]    piece_dt, k, piece_x;
  logic            piece_sb, piece_final;
  logic [4*W-1:0]  cmd;

  assign in_t = in_data[2*W-1:W];
  assign in_x = in_data[W-1:0];

  always_comb begin
    dt     = t1_q - t0_q;
    h      = (W'(0) - t0_q) & BMASK;
    head   = (h < dt) ? h : dt;
    rest   = dt - head;
    body   = rest & ~BMASK;
    tail   = rest & BMASK;
    diff   = {in_x[W-1], in_x} - {x0_q[W-1], x0_q};
    mag    = W'(diff[W] ? -diff : diff);
    bad_t1 = (in_t <= t0_q) || ((in_t - t0_q) > MAXDT);
    // Remainder always stays below dt, which is at most 2^(W-1)-1.
    rem_sh = {rem_q, num_q[2*W-1]};
    q_bit  = (rem_sh >= dt);
    slope  = neg_q ? -num_q : num_q;

    piece_dt    = '0;
    k           = '0;
    piece_sb    = 1'b0;
    piece_final = 1'b0;
    case (state_q)
      EMIT_HEAD: begin
        piece_dt    = head;
        piece_final = (body == '0) && (tail == '0);
      end
      EMIT_BODY: begin
        piece_dt    = body;
        k           = head;
        piece_sb    = 1'b1;
        piece_final = (tail == '0);
      end
      EMIT_TAIL: begin
        piece_dt    = tail;
        k           = head + body;
        piece_final = 1'b1;
      end
      default: ;
    endcase
    k_ext   = {{W{1'b0}}, k};
    piece_x = x0_q + W'(($signed(slope) * $signed(k_ext)) >>> W);
    cmd     = {piece_x, slope, (W-1)'(piece_dt), piece_sb};
  end

  assign out_valid = (state_q == EMIT_HEAD) || (state_q == EMIT_BODY) || (state_q == EMIT_TAIL);
  assign in_ready  = ready_en_q && ((state_q == IDLE) || (state_q == LOAD) || (state_q == ERROR));
  assign out_data  = out_valid ? DMA_DATA_WIDTH'(cmd) : '0;
  assign out_last  = out_valid && piece_final && last_q;
  assign error     = error_q;
  assign in_acc    = in_valid && in_ready;
  assign out_acc   = out_valid && out_ready;

  always_comb begin
    state_d    = state_q;
    ready_en_d = 1'b1;
    error_d    = error_q;
    last_d     = last_q;
    neg_d      = neg_q;
    t0_d       = t0_q;
    x0_d       = x0_q;
    t1_d       = t1_q;
    x1_d       = x1_q;
    num_d      = num_q;
    rem_d      = rem_q;
    cnt_d      = cnt_q;
    case (state_q)
      IDLE: if (in_acc) begin
        if (in_t != '0 || in_last) begin
          state_d = ERROR;
          error_d = 1'b1;
        end else begin
          t0_d    = in_t;
          x0_d    = in_x;
          error_d = 1'b0;
          state_d = LOAD;
        end
      end
      LOAD: if (in_acc) begin
        if (bad_t1) begin
          state_d = ERROR;
          error_d = 1'b1;
        end else begin
          t1_d    = in_t;
          x1_d    = in_x;
          last_d  = in_last;
          neg_d   = diff[W];
          num_d   = {mag, {W{1'b0}}};
          rem_d   = '0;
          cnt_d   = '0;
          state_d = DIVIDE;
        end
      end
      DIVIDE: begin
        num_d = {num_q[2*W-2:0], q_bit};
        rem_d = (W-1)'(q_bit ? rem_sh - dt : rem_sh);
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(2*W-1))
          state_d = (head != '0) ? EMIT_HEAD : (body != '0) ? EMIT_BODY : EMIT_TAIL;
      end
      EMIT_HEAD, EMIT_BODY, EMIT_TAIL: if (out_acc) begin
        if (piece_final) begin
          if (last_q) begin
            state_d = IDLE;
          end else begin
            t0_d    = t1_q;
            x0_d    = x1_q;
            state_d = LOAD;
          end
        end else if (state_q == EMIT_HEAD) begin
          state_d = (body != '0) ? EMIT_BODY : EMIT_TAIL;
        end else begin
          state_d = EMIT_TAIL;
        end
      end
      ERROR: if (in_acc && in_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      ready_en_q <= 1'b0;
      error_q    <= 1'b0;
      last_q     <= 1'b0;
      neg_q      <= 1'b0;
      t0_q       <= '0;
      x0_q       <= '0;
      t1_q       <= '0;
      x1_q       <= '0;
      num_q      <= '0;
      rem_q      <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      ready_en_q <= ready_en_d;
      error_q    <= error_d;
      last_q     <= last_d;
      neg_q      <= neg_d;
      t0_q       <= t0_d;
      x0_q       <= x0_d;
      t1_q       <= t1_d;
      x1_q       <= x1_d;
      num_q      <= num_d;
      rem_q      <= rem_d;
      cnt_q      <= cnt_d;
    end
  end
endmodule

// File: tb/tb_pwl_cmd_builder.sv
// tb/tb_pwl_cmd_builder.sv - directed self-checking bench for pwl_cmd_builder
module tb_pwl_cmd_builder;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_last = 1'b0;
  logic [63:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        out_last;
  logic        error;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  pwl_cmd_builder #(.SAMPLE_WIDTH(16), .BATCH_SIZE(16), .DMA_DATA_WIDTH(64)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .error(error)
  );

  function automatic logic [63:0] cmd(input logic [15:0] x, input logic [31:0] s,
                                      input logic [14:0] dt, input logic sb);
    return {x, s, dt, sb};
  endfunction

  task automatic send_bp(input logic [15:0] t, input logic [15:0] x, input logic last);
    int n;
    @(negedge clk);
    in_data = {t, x};
    in_last = last;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL send_timeout t=%0d in_ready=%b required 1", t, in_ready);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic recv_word(output logic [63:0] d, output logic l, output int waited);
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (!out_valid && waited < 200);
    d = out_valid ? out_data : 64'hx;
    l = out_valid ? out_last : 1'bx;
    if (out_valid) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    #2;
    vectors++;
    if ({in_ready, out_valid, out_last, error} !== 4'b0 || out_data !== 64'h0) begin
      miscompares++;
      $display("FAIL reset_outputs got rdy=%b vld=%b last=%b err=%b data=%h required all 0",
               in_ready, out_valid, out_last, error, out_data);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    vectors++;
    if (in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_release_ready got %b required 0", in_ready);
    end
    @(negedge clk);
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_first_edge_ready got %b required 1", in_ready);
    end
  endtask

  task automatic test_single_body();
    int n;
    send_bp(16'd0, 16'd0, 1'b0);
    send_bp(16'd32, 16'd16, 1'b1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 10) begin
        vectors++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
          miscompares++;
          $display("FAIL divide_busy got rdy=%b vld=%b required 0 0", in_ready, out_valid);
        end
      end
    end while (!out_valid && n < 100);
    vectors++;
    if (n != 33) begin
      miscompares++;
      $display("FAIL body_latency got %0d required 33", n);
    end
    vectors++;
    if (out_data !== cmd(16'd0, 32'h00008000, 15'd32, 1'b1) || out_last !== 1'b1) begin
      miscompares++;
      $display("FAIL body_word got %h last=%b required %h last=1", out_data, out_last,
               cmd(16'd0, 32'h00008000, 15'd32, 1'b1));
    end
    @(posedge clk);
    #1;
    @(negedge clk);
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL body_done got vld=%b rdy=%b required 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_tail_only();
    logic [63:0] d;
    logic l;
    int w;
    send_bp(16'd0, 16'd0, 1'b0);
    send_bp(16'd5, 16'd100, 1'b1);
    recv_word(d, l, w);
    vectors++;
    if (d !== cmd(16'd0, 32'h00140000, 15'd5, 1'b0) || l !== 1'b1) begin
      miscompares++;
      $display("FAIL tail_word got %h last=%b required %h last=1", d, l,
               cmd(16'd0, 32'h00140000, 15'd5, 1'b0));
    end
  endtask

  task automatic test_multi_region();
    logic [63:0] d;
    logic l;
    int w;
    logic [63:0] exp_d [4];
    logic exp_l [4];
    int exp_w [4];
    exp_d[0] = cmd(16'd0,  32'h00000000, 15'd10, 1'b0); exp_l[0] = 1'b0; exp_w[0] = 33;
    exp_d[1] = cmd(16'd0,  32'h00020000, 15'd6,  1'b0); exp_l[1] = 1'b0; exp_w[1] = 33;
    exp_d[2] = cmd(16'd12, 32'h00020000, 15'd16, 1'b1); exp_l[2] = 1'b0; exp_w[2] = 1;
    exp_d[3] = cmd(16'd44, 32'h00020000, 15'd8,  1'b0); exp_l[3] = 1'b1; exp_w[3] = 1;
    send_bp(16'd0, 16'd0, 1'b0);
    send_bp(16'd10, 16'd0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      if (i == 1) send_bp(16'd40, 16'd60, 1'b1);
      recv_word(d, l, w);
      vectors++;
      if (d !== exp_d[i] || l !== exp_l[i] || w != exp_w[i]) begin
        miscompares++;
        $display("FAIL multi_word%0d got %h last=%b wait=%0d required %h last=%b wait=%0d",
                 i, d, l, w, exp_d[i], exp_l[i], exp_w[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    int n;
    logic [63:0] exp_d;
    exp_d = cmd(16'd100, 32'hFFFE0000, 15'd16, 1'b1);
    out_ready = 1'b0;
    send_bp(16'd0, 16'd100, 1'b0);
    send_bp(16'd16, 16'd68, 1'b1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 100);
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if (out_valid !== 1'b1 || out_data !== exp_d || out_last !== 1'b1) begin
        miscompares++;
        $display("FAIL stall_hold%0d got vld=%b %h last=%b required 1 %h 1",
                 i, out_valid, out_data, out_last, exp_d);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL stall_release got vld=%b required 0", out_valid);
    end
  endtask

  task automatic test_error();
    logic [63:0] d;
    logic l;
    int w;
    int seen;
    send_bp(16'd0, 16'd0, 1'b0);
    send_bp(16'd0, 16'd5, 1'b0);
    @(negedge clk);
    vectors++;
    if (error !== 1'b1 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL error_enter got err=%b rdy=%b vld=%b required 1 1 0", error, in_ready, out_valid);
    end
    send_bp(16'd9, 16'd1, 1'b1);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    vectors++;
    if (seen != 0 || error !== 1'b1) begin
      miscompares++;
      $display("FAIL error_drain got valid_cycles=%0d err=%b required 0 1", seen, error);
    end
    send_bp(16'd0, 16'd0, 1'b0);
    @(negedge clk);
    vectors++;
    if (error !== 1'b0) begin
      miscompares++;
      $display("FAIL error_clear got %b required 0", error);
    end
    send_bp(16'd4, 16'd8, 1'b1);
    recv_word(d, l, w);
    vectors++;
    if (d !== cmd(16'd0, 32'h00020000, 15'd4, 1'b0) || l !== 1'b1) begin
      miscompares++;
      $display("FAIL error_recover got %h last=%b required %h last=1", d, l,
               cmd(16'd0, 32'h00020000, 15'd4, 1'b0));
    end
  endtask

  task automatic test_first_last_error();
    logic [63:0] d;
    logic l;
    int w;
    send_bp(16'd0, 16'd0, 1'b1);
    @(negedge clk);
    vectors++;
    if (error !== 1'b1) begin
      miscompares++;
      $display("FAIL first_last_error got %b required 1", error);
    end
    send_bp(16'd7, 16'd7, 1'b0);
    send_bp(16'd3, 16'd3, 1'b1);
    send_bp(16'd0, 16'd2, 1'b0);
    @(negedge clk);
    vectors++;
    if (error !== 1'b0) begin
      miscompares++;
      $display("FAIL first_last_clear got %b required 0", error);
    end
    send_bp(16'd2, 16'd4, 1'b1);
    recv_word(d, l, w);
    vectors++;
    if (d !== cmd(16'd2, 32'h00010000, 15'd2, 1'b0) || l !== 1'b1) begin
      miscompares++;
      $display("FAIL first_last_recover got %h last=%b required %h last=1", d, l,
               cmd(16'd2, 32'h00010000, 15'd2, 1'b0));
    end
  endtask

  task automatic test_reset_mid_divide();
    int seen;
    send_bp(16'd0, 16'd0, 1'b0);
    send_bp(16'd32, 16'd16, 1'b1);
    repeat (10) @(negedge clk);
    #1;
    rst = 1'b0;
    #1;
    vectors++;
    if ({in_ready, out_valid, out_last, error} !== 4'b0 || out_data !== 64'h0) begin
      miscompares++;
      $display("FAIL mid_reset_outputs got rdy=%b vld=%b last=%b err=%b data=%h required all 0",
               in_ready, out_valid, out_last, error, out_data);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_reset_ready got %b required 1", in_ready);
    end
    seen = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    vectors++;
    if (seen != 0) begin
      miscompares++;
      $display("FAIL mid_reset_no_output got valid_cycles=%0d required 0", seen);
    end
  endtask

  initial begin
    test_reset();
    test_single_body();
    test_tail_only();
    test_multi_region();
    test_backpressure();
    test_error();
    test_first_last_error();
    test_reset_mid_divide();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/pwl_cmd_builder.md
PWL_CMD_BUILDER -- requirements
Module: pwl_cmd_builder

Interface
REQ-001 SHALL have parameter SAMPLE_WIDTH, default 16, meaning the sample and breakpoint-time width W.
REQ-002 SHALL have parameter BATCH_SIZE, default 16 (power of 2), meaning samples per batch B.
REQ-003 SHALL have parameter DMA_DATA_WIDTH, default 4*SAMPLE_WIDTH, meaning the output command word width.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port in_data, input, 2W bits: breakpoint {t[W-1:0] unsigned sample index, x[W-1:0] signed}.
REQ-007 SHALL have ports in_valid (input, 1), in_ready (output, 1) and in_last (input, 1): the breakpoint handshake; in_last marks the final breakpoint.
REQ-008 SHALL have port out_data, output, DMA_DATA_WIDTH bits: the region command {x[W-1:0], slope[2W-1:0] signed Q(W.W), dt[W-2:0], sb}.
REQ-009 SHALL have ports out_valid (output, 1), out_ready (input, 1) and out_last (output, 1): the command stream to pwl_generator's dma port.
REQ-010 SHALL have port error, output, 1 bit: malformed breakpoint sequence detected.

Function
REQ-011 Handshakes: a transfer occurs on a cycle with valid && ready. While out_valid=1 and out_ready=0, out_data and out_last SHALL hold stable.
REQ-012 States:
- IDLE: in_ready=1. Accepting a breakpoint stores (t0,x0), clears error and goes to LOAD.
- LOAD: in_ready=1. Accepting a breakpoint stores (t1,x1) and goes to DIVIDE.
- DIVIDE: computes the slope.
- EMIT_HEAD, EMIT_BODY, EMIT_TAIL: output the region pieces.
- ERROR: drains input.
REQ-013 The first breakpoint of a sequence SHALL have t=0; otherwise go to ERROR. If in_last is set on the first breakpoint, go to ERROR.
REQ-014 On the LOAD accept, if t1<=t0 or t1-t0>2^(W-1)-1, go to ERROR.
REQ-015 Slope = ((x1-x0) sign-extended, <<W) / (t1-t0), truncated toward zero. Compute it with a sequential restoring divider on magnitudes, one quotient bit per cycle, and negate the result if the numerator is negative. DIVIDE SHALL last exactly 2W cycles.
REQ-016 Region splitting, with dt=t1-t0:
- h = (B - t0 mod B) mod B.
- head dt = min(h, dt).
- body dt = floor((dt-head)/B)*B.
- tail dt = the remainder.
- Emit only the nonzero pieces, in order head, body, tail.
REQ-017 sb SHALL be 1 for body pieces and 0 for head and tail pieces. Head and tail pieces never cross a B-aligned boundary.
REQ-018 Piece x SHALL be x0 + ((slope*k) >>> W), truncated to W bits, where k is the piece's start offset from t0. Every piece SHALL carry the same slope.
REQ-019 First out_valid SHALL assert on the cycle after DIVIDE ends, i.e. 2W+1 cycles after the LOAD accept. Consecutive pieces SHALL be issued back-to-back when out_ready=1.
REQ-020 After the final piece transfers, state and output SHALL follow this rule:
- If the (t1,x1) breakpoint carried in_last: out_last=1 on that final piece, then go to IDLE.
- Otherwise: (t1,x1) becomes (t0,x0) and the block goes to LOAD.
REQ-021 ERROR:
- error=1; in_ready=1; out_valid=0.
- Breakpoints are discarded until a transfer with in_last=1, then go to IDLE.
- error remains 1 until the next IDLE accept.
REQ-022 in_ready SHALL be 0 in DIVIDE and all EMIT states (no input is accepted while a region is in progress).

Reset
REQ-023 While rst=0, regardless of clock:
- state=IDLE.
- in_ready=0, out_valid=0, out_last=0, out_data=0, error=0.
- Divider and piece registers are cleared.
REQ-024 in_ready SHALL rise on the first clk edge after rst deasserts. Reset mid-DIVIDE or mid-EMIT SHALL abort the region with no further output.

Verification (W=16, B=16)
REQ-025 Breakpoints (0,0),(32,16,last) -> one word: x=0, slope=0x00008000, dt=32, sb=1, out_last=1, with out_valid asserting 33 cycles after the second accept.
REQ-026 Breakpoints (0,0),(5,100,last) -> x=0, slope=0x00140000, dt=5, sb=0, last=1.
REQ-027 Breakpoints (0,0),(10,0),(40,60,last) -> four words, in order:
- {x=0, slope=0, dt=10, sb=0}
- {x=0, slope=0x00020000, dt=6, sb=0}
- {x=12, dt=16, sb=1}
- {x=44, dt=8, sb=0, last=1}
REQ-028 Breakpoints (0,100),(16,68,last) -> slope=0xFFFE0000, dt=16, sb=1, x=100. Hold out_ready=0 for 5 cycles; out_data SHALL stay stable.
REQ-029 Breakpoints (0,0),(0,5),(9,1,last) -> error=1, no out_valid, IDLE after the last accept. Error clears on the next accepted breakpoint.
REQ-030 Pulse rst=0 at DIVIDE cycle 10 -> outputs go to reset values immediately, no output words follow, and in_ready=1 one cycle after release.
